// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default byte
// width and the cyclic index helper used by the round-robin picker.
package uart_pkg;

   localparam int DBIT_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } arb_state_t;

   // Next index on a ring of n requesters.
   function automatic int cyc_next(input int idx, input int n);
      if (idx >= n - 32'sd1) begin
         return 32'sd0;
      end else begin
         return idx + 32'sd1;
      end
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first requester with req high, searching
// cyclically from the slot just after rr_ptr.
module uart_rr_pick import uart_pkg::*; #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   rr_ptr,
   output logic            grant_valid,
   output logic [IW-1:0]   grant
);

   // Walk the ring once; only the first hit is kept.
   always_comb begin
      logic [IW-1:0] cand;
      logic          hit;
      grant_valid = 1'b0;
      grant       = {IW{1'b0}};
      cand        = rr_ptr;
      hit         = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand        = IW'(cyc_next(int'(cand), NREQ));
         hit         = !grant_valid && req[cand];
         grant       = hit ? cand : grant;
         grant_valid = grant_valid | hit;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NREQ requesters;
// the owner keeps the transmitter until its last byte completes or the hold times out.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int NREQ         = 4,
   parameter int DBIT         = DBIT_DEFAULT,
   parameter int HOLD_TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          last,
   input  logic [NREQ*DBIT-1:0]     din,
   output logic [NREQ-1:0]          ack,
   output logic                     tx_start,
   output logic [DBIT-1:0]          tx_din,
   input  logic                     tx_done_tick,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic                     abort
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT + 1);

   arb_state_t      state_r, next_state_s;
   logic [IW-1:0]   rr_ptr_r, owner_r, grant_s;
   logic            grant_valid_s;
   logic [DBIT-1:0] tx_din_r;
   logic            last_r, abort_r;
   logic [CW-1:0]   hold_cnt_r, hold_cnt_inc_s;
   logic            timeout_s;
   logic [NREQ-1:0] ack_s;

   uart_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req         (req),
      .rr_ptr      (rr_ptr_r),
      .grant_valid (grant_valid_s),
      .grant       (grant_s)
   );

   assign hold_cnt_inc_s = hold_cnt_r + CW'(1'b1);
   assign timeout_s      = (HOLD_TIMEOUT != 32'sd0) && (hold_cnt_inc_s == CW'(HOLD_TIMEOUT));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    next_state_s = grant_valid_s ? START : IDLE;
         START:   next_state_s = WAIT;
         WAIT: begin
            if (tx_done_tick) begin
               next_state_s = last_r ? IDLE : HOLD;
            end else begin
               next_state_s = WAIT;
            end
         end
         HOLD: begin
            if (req[owner_r]) begin
               next_state_s = START;
            end else if (timeout_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = HOLD;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Ready decode: the picker winner in IDLE, only the lock owner in HOLD.
   always_comb begin
      ack_s = {NREQ{1'b0}};
      case (state_r)
         IDLE: begin
            if (grant_valid_s) begin
               ack_s[grant_s] = 1'b1;
            end else begin
               ack_s = {NREQ{1'b0}};
            end
         end
         HOLD:    ack_s[owner_r] = req[owner_r];
         default: ack_s = {NREQ{1'b0}};
      endcase
   end

   // Byte, ownership, round-robin pointer and hold-timeout bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_din_r   <= {DBIT{1'b0}};
         last_r     <= 1'b0;
         owner_r    <= {IW{1'b0}};
         rr_ptr_r   <= IW'(NREQ - 1);
         hold_cnt_r <= {CW{1'b0}};
         abort_r    <= 1'b0;
      end else begin
         abort_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  tx_din_r <= din[int'(grant_s)*DBIT +: DBIT];
                  last_r   <= last[grant_s];
                  owner_r  <= grant_s;
               end
            end
            WAIT: begin
               if (tx_done_tick) begin
                  if (last_r) begin
                     rr_ptr_r <= owner_r;
                  end else begin
                     hold_cnt_r <= {CW{1'b0}};
                  end
               end
            end
            HOLD: begin
               if (req[owner_r]) begin
                  tx_din_r <= din[int'(owner_r)*DBIT +: DBIT];
                  last_r   <= last[owner_r];
               end else if (timeout_s) begin
                  abort_r  <= 1'b1;
                  rr_ptr_r <= owner_r;
               end else begin
                  hold_cnt_r <= hold_cnt_inc_s;
               end
            end
            default: begin
               abort_r <= 1'b0;
            end
         endcase
      end
   end

   assign ack      = reset ? {NREQ{1'b0}} : ack_s;
   assign tx_start = (state_r == START);
   assign busy     = (state_r != IDLE);
   assign tx_din   = tx_din_r;
   assign owner    = owner_r;
   assign abort    = abort_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: a packet-level arbitration model checked every cycle,
// plus directed scenarios with hand-computed grant/byte/abort expectations.
module tb_uart_tx_arbiter;

   localparam int HT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req, last, ack;
   logic [31:0] din;
   logic        tx_start, busy, abort, tx_done_tick;
   logic [7:0]  tx_din;
   logic [1:0]  owner;
   logic        auto_done, man_done, auto_en;

   logic [3:0]  z_req, z_last, z_ack;
   logic [31:0] z_din;
   logic        z_tx_start, z_busy, z_abort, z_done;
   logic [7:0]  z_tx_din;
   logic [1:0]  z_owner;

   assign tx_done_tick = auto_done | man_done;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(4), .DBIT(8), .HOLD_TIMEOUT(HT)) dut (
      .clk(clk), .reset(reset), .req(req), .last(last), .din(din), .ack(ack),
      .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
      .busy(busy), .owner(owner), .abort(abort)
   );

   uart_tx_arbiter #(.NREQ(4), .DBIT(8), .HOLD_TIMEOUT(0)) dut0 (
      .clk(clk), .reset(reset), .req(z_req), .last(z_last), .din(z_din), .ack(z_ack),
      .tx_start(z_tx_start), .tx_din(z_tx_din), .tx_done_tick(z_done),
      .busy(z_busy), .owner(z_owner), .abort(z_abort)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // requester byte queues {last, byte}
   logic [8:0] rq_mem [4][16];
   int         rq_head [4];
   int         rq_tail [4];
   logic [3:0] xfer_d;

   task automatic push(input int i, input logic l, input logic [7:0] b);
      rq_mem[i][rq_tail[i]] = {l, b};
      rq_tail[i]++;
   endtask

   // logs of what the DUT actually did
   int         g_log[$];
   logic [7:0] t_log[$];
   int         cyc = 0, last_done_cyc = 0, abort_cnt = 0, abort_gap = 0;

   // model state
   logic       m_locked, m_start_due, m_inflight, m_abort_due, m_last;
   int         m_owner, m_rr, m_hold;
   logic [7:0] m_byte;

   function automatic int pick(input logic [3:0] r, input int rr);
      for (int k = 1; k <= 4; k++) begin
         if (r[(rr + k) % 4]) return (rr + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_locked = 1'b0; m_start_due = 1'b0; m_inflight = 1'b0; m_abort_due = 1'b0;
      m_last = 1'b0; m_owner = 0; m_rr = 3; m_hold = 0; m_byte = 8'h00;
   endtask

   // requester driver
   initial begin
      req = 4'b0; last = 4'b0; din = 32'b0;
      for (int i = 0; i < 4; i++) begin rq_head[i] = 0; rq_tail[i] = 0; end
      forever begin
         @(negedge clk);
         xfer_d = reset ? 4'b0 : (req & ack);
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            if (xfer_d[i]) rq_head[i]++;
            if (rq_head[i] < rq_tail[i]) begin
               req[i] = 1'b1;
               last[i] = rq_mem[i][rq_head[i]][8];
               din[i*8 +: 8] = rq_mem[i][rq_head[i]][7:0];
            end else begin
               req[i] = 1'b0;
               last[i] = 1'b0;
            end
         end
      end
   end

   // uart_tx stand-in: done four cycles after the start pulse
   initial begin
      auto_done = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_en && tx_start === 1'b1) begin
            repeat (4) @(posedge clk);
            #1;
            if (!reset && auto_en) begin
               auto_done = 1'b1;
               @(posedge clk); #1;
               auto_done = 1'b0;
            end
         end
      end
   end

   // per-cycle compare against the packet-level model
   initial begin
      logic [3:0] exp_ack;
      logic nxt_start, nxt_abort;
      int w;
      model_reset();
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            chk("rst_ack", ack, 4'b0);
            chk("rst_tx_start", tx_start, 1'b0);
            chk("rst_tx_din", tx_din, 8'h00);
            chk("rst_busy", busy, 1'b0);
            chk("rst_owner", owner, 2'd0);
            chk("rst_abort", abort, 1'b0);
            model_reset();
         end else begin
            w = pick(req, m_rr);
            exp_ack = 4'b0;
            if (!m_locked) begin
               if (w >= 0) exp_ack[w] = 1'b1;
            end else if (!m_start_due && !m_inflight && req[m_owner]) begin
               exp_ack[m_owner] = 1'b1;
            end
            chk("ack", ack, exp_ack);
            chk("tx_start", tx_start, m_start_due);
            chk("busy", busy, m_locked);
            chk("owner", owner, m_owner);
            chk("tx_din", tx_din, m_byte);
            chk("abort", abort, m_abort_due);
            for (int i = 0; i < 4; i++) if (req[i] && ack[i]) g_log.push_back(i);
            if (tx_start) t_log.push_back(tx_din);
            if (tx_done_tick) last_done_cyc = cyc;
            if (abort) begin abort_cnt++; abort_gap = cyc - last_done_cyc; end
            nxt_start = 1'b0; nxt_abort = 1'b0;
            if (!m_locked) begin
               if (w >= 0) begin
                  m_locked = 1'b1; m_owner = w; m_byte = din[w*8 +: 8]; m_last = last[w];
                  nxt_start = 1'b1;
               end
            end else if (m_start_due) begin
               m_inflight = 1'b1;
            end else if (m_inflight) begin
               if (tx_done_tick) begin
                  m_inflight = 1'b0;
                  if (m_last) begin m_locked = 1'b0; m_rr = m_owner; end
                  else m_hold = 0;
               end
            end else if (req[m_owner]) begin
               m_byte = din[m_owner*8 +: 8]; m_last = last[m_owner]; nxt_start = 1'b1;
            end else begin
               m_hold++;
               if (m_hold == HT) begin m_locked = 1'b0; m_rr = m_owner; nxt_abort = 1'b1; end
            end
            m_start_due = nxt_start;
            m_abort_due = nxt_abort;
         end
      end
   end

   task automatic wait_ack(input int i);
      bit ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (req[i] && ack[i]) begin ok = 1'b1; break; end
      end
      chk("wait_ack_bound", ok, 1'b1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (!busy && req == 4'b0 && !tx_start) begin ok = 1'b1; break; end
      end
      chk("wait_idle_bound", ok, 1'b1);
   endtask

   task automatic chk_glog(input string name, input int exp[$]);
      chk({name, "_len"}, g_log.size(), exp.size());
      for (int k = 0; k < exp.size() && k < g_log.size(); k++) chk(name, g_log[k], exp[k]);
   endtask

   task automatic chk_tlog(input string name, input logic [7:0] exp[$]);
      chk({name, "_len"}, t_log.size(), exp.size());
      for (int k = 0; k < exp.size() && k < t_log.size(); k++) chk(name, t_log[k], exp[k]);
   endtask

   task automatic z_wait(input string name, input bit want_ack);
      bit ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (want_ack ? z_ack[3] : z_tx_start) begin ok = 1'b1; break; end
      end
      chk(name, ok, 1'b1);
   endtask

   // directed scenarios
   initial begin
      bit ok;
      auto_en = 1'b1; man_done = 1'b0;
      z_req = 4'b0; z_last = 4'b0; z_din = 32'b0; z_done = 1'b0;
      #2 reset = 1'b1;

      // single byte, presented while reset is still high
      push(2, 1'b1, 8'hA5);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack_forced", ack, 4'b0000);
      @(posedge clk); #1 reset = 1'b0;
      wait_ack(2);
      chk("single_ack", ack, 4'b0100);
      @(negedge clk);
      chk("single_start", tx_start, 1'b1);
      chk("single_tx_din", tx_din, 8'hA5);
      wait_idle();
      chk_glog("single_grant", '{2});
      chk("single_owner", owner, 2'd2);

      // round robin after a fresh reset
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk); #1 reset = 1'b0;
      g_log.delete(); t_log.delete();
      push(0, 1'b1, 8'hB0); push(0, 1'b1, 8'hB4);
      push(1, 1'b1, 8'hB1); push(2, 1'b1, 8'hB2); push(3, 1'b1, 8'hB3);
      wait_ack(0);
      wait_idle();
      chk_glog("rr_order", '{0, 1, 2, 3, 0});
      chk_tlog("rr_bytes", '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4});

      // packet lock
      g_log.delete(); t_log.delete();
      push(1, 1'b0, 8'h01); push(1, 1'b0, 8'h02); push(1, 1'b1, 8'h03);
      push(0, 1'b1, 8'hC0);
      wait_ack(1);
      wait_idle();
      chk_glog("lock_order", '{1, 1, 1, 0});
      chk_tlog("lock_bytes", '{8'h01, 8'h02, 8'h03, 8'hC0});

      // hold timeout
      g_log.delete(); t_log.delete(); abort_cnt = 0;
      push(3, 1'b0, 8'h5E);
      wait_ack(3);
      push(0, 1'b1, 8'hD0); push(1, 1'b1, 8'hD1);
      wait_idle();
      chk("hold_abort_count", abort_cnt, 1);
      chk("hold_abort_gap", abort_gap, 9);
      chk_glog("hold_order", '{3, 0, 1});
      chk_tlog("hold_bytes", '{8'h5E, 8'hD0, 8'hD1});

      // stray done ticks in IDLE and START
      auto_en = 1'b0; g_log.delete(); t_log.delete();
      @(posedge clk); #1 man_done = 1'b1;
      @(posedge clk); #1 man_done = 1'b0;
      @(negedge clk);
      chk("stray_idle_busy", busy, 1'b0);
      chk("stray_idle_start", tx_start, 1'b0);
      push(1, 1'b1, 8'h77);
      wait_ack(1);
      @(posedge clk); #1 man_done = 1'b1;
      @(negedge clk);
      chk("stray_in_start", tx_start, 1'b1);
      @(posedge clk); #1 man_done = 1'b0;
      @(negedge clk);
      chk("stray_start_ignored", busy, 1'b1);
      repeat (2) @(posedge clk); #1 man_done = 1'b1;
      @(posedge clk); #1 man_done = 1'b0;
      @(negedge clk);
      chk("stray_real_done", busy, 1'b0);
      chk_tlog("stray_bytes", '{8'h77});
      auto_en = 1'b1;

      // reset during WAIT of byte 2 of a 4-byte packet
      g_log.delete(); t_log.delete();
      push(2, 1'b0, 8'h10); push(2, 1'b0, 8'h11); push(2, 1'b0, 8'h12); push(2, 1'b1, 8'h13);
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (t_log.size() >= 2) begin ok = 1'b1; break; end
      end
      chk("mid_reach_byte2", ok, 1'b1);
      @(posedge clk); #1 reset = 1'b1;
      rq_head[2] = rq_tail[2];
      #1;
      chk("mid_async_busy", busy, 1'b0);
      chk("mid_async_owner", owner, 2'd0);
      chk("mid_async_tx_din", tx_din, 8'h00);
      chk("mid_async_ack", ack, 4'b0000);
      repeat (6) @(posedge clk); #1 reset = 1'b0;
      g_log.delete();
      push(0, 1'b1, 8'hE0); push(3, 1'b1, 8'hE3);
      wait_ack(0);
      wait_idle();
      push(1, 1'b1, 8'hE1);
      wait_ack(1);
      wait_idle();
      chk_glog("post_reset_order", '{0, 3, 1});

      // HOLD_TIMEOUT = 0 never aborts
      @(posedge clk); #1 z_req = 4'b1000; z_last = 4'b0000; z_din[31:24] = 8'h3C;
      z_wait("z_ack1", 1'b1);
      @(posedge clk); #1 z_req = 4'b0000;
      z_wait("z_start1", 1'b0);
      chk("z_tx_din1", z_tx_din, 8'h3C);
      repeat (3) @(posedge clk); #1 z_done = 1'b1;
      @(posedge clk); #1 z_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         chk("z_no_abort", z_abort, 1'b0);
         chk("z_hold_busy", z_busy, 1'b1);
      end
      @(posedge clk); #1 z_req = 4'b1000; z_last = 4'b1000; z_din[31:24] = 8'h3D;
      z_wait("z_ack2", 1'b1);
      @(posedge clk); #1 z_req = 4'b0000; z_last = 4'b0000;
      z_wait("z_start2", 1'b0);
      chk("z_tx_din2", z_tx_din, 8'h3D);
      repeat (3) @(posedge clk); #1 z_done = 1'b1;
      @(posedge clk); #1 z_done = 1'b0;
      @(negedge clk);
      chk("z_idle", z_busy, 1'b0);
      chk("z_owner", z_owner, 2'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter among NREQ requesters, such as a command responder, a status logger and a debug port.
- Arbitration is round-robin at packet granularity. A packet is one or more bytes, terminated by a `last` flag. Once granted, the owner keeps the transmitter until its last byte finishes, so bytes from different packets never interleave on the line.
- Sits between the requesters and uart_tx. Drives uart_tx's tx_start/tx_din and consumes its tx_done_tick.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DBIT, 8, data bits per byte; must match the connected uart_tx
- HOLD_TIMEOUT, 1023, clk cycles the owner may leave req low mid-packet before the lock is revoked; 0 disables the timeout

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester valid: a byte is presented on din slice i
- last  in  NREQ  per-requester flag: the presented byte ends the packet
- din  in  NREQ*DBIT  byte for requester i on bits [i*DBIT +: DBIT]
- ack  out  NREQ  one-hot ready; a byte transfers on a clk edge where req[i] && ack[i]
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_din  out  DBIT  byte to uart_tx; held stable from tx_start until tx_done_tick
- tx_done_tick  in  1  uart_tx stop-bit completion pulse
- busy  out  1  high in every state except IDLE
- owner  out  $clog2(NREQ)  index of the current or most recent grant
- abort  out  1  one-cycle pulse when a packet lock is revoked by timeout

Behaviour:
- Reset values (asserted or released): state=IDLE; ack=0 (forced to 0 while reset is high); tx_start=0; tx_din=0; busy=0; owner=0; abort=0; rr_ptr=NREQ-1, so requester 0 has first priority; timeout counter=0.
- IDLE:
  - If any req is high, grant g = the first requester with req high, searching cyclically from rr_ptr+1.
  - ack[g] is asserted combinationally in the same cycle.
  - On that edge: tx_din<=din[g], last_q<=last[g], owner<=g, go to START.
  - If no req is high, remain in IDLE.
- START: tx_start=1 for exactly one cycle, then go to WAIT. Latency from the accepting edge to tx_start high is 1 cycle.
- WAIT: ack=0 for all requesters. On tx_done_tick:
  - if last_q=1: rr_ptr<=owner, go to IDLE;
  - otherwise: clear the timeout counter and go to HOLD.
- HOLD (owner keeps the lock):
  - ack[owner]=req[owner]; all other acks are 0.
  - On a transfer: tx_din<=din[owner], last_q<=last[owner], go to START.
  - Otherwise the counter increments each cycle. If HOLD_TIMEOUT!=0 and the counter reaches HOLD_TIMEOUT: pulse abort for one cycle, rr_ptr<=owner, go to IDLE.
- Spacing: after tx_done_tick there are at least 2 cycles before the next tx_start. uart_tx is guaranteed to have returned to its idle state.
- Simultaneous requests in IDLE: only the round-robin winner is acked. Losers keep req high and stall.
- Requests from non-owners during START/WAIT/HOLD are ignored; their ack stays 0.
- A tx_done_tick arriving outside WAIT is ignored.
- Deasserting req without a transfer is legal and has no effect.
- Reset mid-packet aborts immediately and returns to IDLE with reset values. The byte already in uart_tx is that block's concern; uart_tx shares the same reset.
- At most one ack bit is high in any cycle. ack never depends on tx_done_tick in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams IDLE=0, START=1, WAIT=2, HOLD=3
  - DBIT default
  - a shared function for the cyclic next index
- One sub-module, uart_rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], rr_ptr.
  - Outputs: grant_valid, grant index.
  - Verified standalone.
- The top module holds the FSM, the byte/last/owner registers and the timeout counter.

Test Plan:
- Single byte: after reset, req[2]=1, last[2]=1, din[2]=8'hA5 -> ack[2] for 1 cycle; tx_start 1 cycle later with tx_din=8'hA5; busy falls 1 cycle after tx_done_tick; owner=2.
- Round-robin: req=4'b1111 held, every byte with last=1 -> grant order 0,1,2,3,0; each ack is a single pulse per byte.
- Packet lock: req[1] sends 3 bytes (8'h01, 8'h02, 8'h03; last on the third) while req[0] is high throughout -> 3 consecutive transfers from requester 1 with no ack[0], then requester 0 is granted; tx_din sequence is 01, 02, 03, then din[0].
- Hold timeout, HOLD_TIMEOUT=8: owner 3 sends a byte with last=0, then drops req -> abort pulses exactly 8 cycles after HOLD is entered; returns to IDLE; requester 0 is granted next; a second test with HOLD_TIMEOUT=0 never aborts.
- Reset mid-packet: assert reset during WAIT of byte 2 of a 4-byte packet -> all outputs take reset values asynchronously; after release, req[1] alone is granted normally and requester 0 has top priority again.
- Stray done: pulse tx_done_tick in IDLE and in START -> no state change, no ack, no tx_start.
